// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port framebuffer SRAM between the display line
//   prefetch and a pixel writer. Display fetch has priority. During a
//   fetch the writer is offered one slot after every WR_SLOT_PERIOD reads.
//   A slot the writer does not use costs no cycle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   line_req, line_idx  one-cycle request to fetch display line line_idx
//   lb_we/lb_waddr      line buffer write strobe and column (registered)
//   lb_wdata            line buffer data, straight from sram_rdata
//   line_done           one-cycle pulse after the last line buffer write
//   wr_req/addr/data    writer request; held stable until wr_ack
//   wr_ack              one-cycle pulse in the same cycle as the SRAM write
//   sram_addr/we/wdata  SRAM pins (registered)
//   sram_rdata          SRAM read data, valid the cycle after the address
//   busy                high while a line fetch is in progress
//   underrun, clear_err sticky "line_req while busy" flag and its clear
module vga_fb_arbiter #(
  parameter int H_DISP         = 800,
  parameter int V_DISP         = 600,
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  parameter int WR_SLOT_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_req,
  input  logic [9:0]        line_idx,
  output logic              lb_we,
  output logic [9:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              line_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              underrun,
  input  logic              clear_err
);

  localparam int               CNT_W     = (WR_SLOT_PERIOD > 1) ? $clog2(WR_SLOT_PERIOD) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(WR_SLOT_PERIOD - 1);
  localparam logic [9:0]       LAST_COL  = 10'(H_DISP - 1);
  localparam logic [9:0]       LINE_LIM  = 10'(V_DISP);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] new_base;
  logic [9:0]        rd_col;    // column of the most recent read issued
  logic [9:0]        next_col;
  logic [CNT_W-1:0]  rd_cnt;    // reads issued in the current slot group, minus one
  logic              op_rd;     // the SRAM cycle now on the pins is a read
  logic              start_ok;
  logic              grant_ok;
  logic              slot_now;

  assign start_ok = line_req && (line_idx < LINE_LIM);
  // A set wr_ack means the previous edge granted; that request is not granted twice.
  assign grant_ok = wr_req && !wr_ack;
  assign new_base = ADDR_W'(line_idx) * ADDR_W'(H_DISP);
  assign next_col = rd_col + 10'd1;
  assign slot_now = op_rd && (rd_cnt == SLOT_LAST);

  // The read data lands exactly in the cycle lb_we/lb_waddr are presented.
  assign lb_wdata = sram_rdata;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      rd_col     <= '0;
      rd_cnt     <= '0;
      op_rd      <= 1'b0;
      lb_we      <= 1'b0;
      lb_waddr   <= '0;
      line_done  <= 1'b0;
      wr_ack     <= 1'b0;
      sram_addr  <= '0;
      sram_we    <= 1'b0;
      sram_wdata <= '0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; branches below only raise them,
      // so no path can leave a strobe stuck high.
      lb_we     <= 1'b0;
      line_done <= 1'b0;
      wr_ack    <= 1'b0;
      sram_we   <= 1'b0;
      op_rd     <= 1'b0;

      // Set is written after clear so a simultaneous underrun event wins.
      if (clear_err) underrun <= 1'b0;
      if (start_ok && state != IDLE) underrun <= 1'b1;

      if (start_ok) begin
        // New line, or abort of the current one: the in-flight line buffer
        // write is dropped by leaving lb_we low, and no line_done follows.
        state     <= FETCH;
        busy      <= 1'b1;
        base      <= new_base;
        rd_col    <= '0;
        rd_cnt    <= '0;
        op_rd     <= 1'b1;
        sram_addr <= new_base;
      end else begin
        case (state)
          IDLE: begin
            if (grant_ok) begin
              wr_ack     <= 1'b1;
              sram_we    <= 1'b1;
              sram_addr  <= wr_addr;
              sram_wdata <= wr_data;
            end
          end
          FETCH: begin
            if (op_rd) begin
              lb_we    <= 1'b1;
              lb_waddr <= rd_col;
            end
            if (op_rd && rd_col == LAST_COL) begin
              state <= FLUSH;
            end else if (slot_now && grant_ok) begin
              wr_ack     <= 1'b1;
              sram_we    <= 1'b1;
              sram_addr  <= wr_addr;
              sram_wdata <= wr_data;
              rd_cnt     <= '0;
            end else begin
              // Next read; a skipped slot or a finished write both start a new group.
              op_rd     <= 1'b1;
              rd_col    <= next_col;
              sram_addr <= base + ADDR_W'(next_col);
              rd_cnt    <= (op_rd && !slot_now) ? rd_cnt + CNT_W'(1) : '0;
            end
          end
          FLUSH: begin
            line_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates one single-port 16-bit framebuffer SRAM between two clients: display line prefetch and a pixel writer (drawing engine). Display fetch has priority. When the VGA timing generator requests line `line_idx`, the block streams that line's H_DISP pixels into the display line buffer. It offers the writer a bounded share of SRAM cycles so both the fetch deadline and writer progress are guaranteed. The block sits between the 800x600 VGA timing/pixel path, the drawing logic and the SRAM pin interface.

## Interface
- H_DISP, 800, pixels per line
- V_DISP, 600, lines per frame
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, pixel/SRAM data width
- WR_SLOT_PERIOD, 4, fetch reads between offered writer slots (≥1)

Reset is synchronous and active-high. One clock: `clk`, reset `rst`.

- clk  in  1  system/pixel clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- line_req  in  1  one-cycle pulse: fetch line `line_idx`
- line_idx  in  10  line number to fetch
- lb_we  out  1  line buffer write enable
- lb_waddr  out  10  line buffer column 0..H_DISP-1
- lb_wdata  out  DATA_W  pixel; combinational pass-through of sram_rdata
- line_done  out  1  one-cycle pulse after last lb write of a line
- wr_req  in  1  writer request; addr/data held stable until wr_ack
- wr_addr  in  ADDR_W  writer word address
- wr_data  in  DATA_W  writer pixel
- wr_ack  out  1  one-cycle pulse, coincident with the SRAM write
- sram_addr  out  ADDR_W  SRAM address
- sram_we  out  1  SRAM write strobe, active high
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  read data, valid the cycle after the read address
- busy  out  1  fetch in progress
- underrun  out  1  sticky: line_req arrived while busy
- clear_err  in  1  clears underrun

## Operation
- FSM has three states: IDLE, FETCH and FLUSH.
- IDLE: if line_req is high and line_idx < V_DISP, latch base = line_idx*H_DISP and col = 0, then go to FETCH. Otherwise, a pending wr_req is granted.
- FETCH: each cycle issues a read at base+col, then col++.
  - After every WR_SLOT_PERIOD reads, one slot is offered. If wr_req is high, that cycle is the write. If wr_req is low, the slot is skipped and costs no cycle.
  - No slot is offered after read H_DISP-1.
  - After read H_DISP-1, go to FLUSH.
- FLUSH: performs the final lb write, pulses line_done on the next cycle, then returns to IDLE.
- Read pipeline: a read address presented in cycle c gives lb_we=1 and lb_waddr=col in cycle c+1, with lb_wdata = sram_rdata.
- Address math: unsigned, ADDR_W bits. The maximum address is 479999, so no overflow occurs.
- Write grant no-regrant rule: wr_req is ignored on the edge immediately after a grant. This gives at most one write per 2 cycles and prevents double writes of the same request.
- line_req with line_idx ≥ V_DISP is ignored entirely: no fetch, no underrun.
- line_req while busy:
  - Set underrun.
  - Abort the current line and suppress its in-flight lb write.
  - Restart FETCH at col 0 of the new line.
  - No line_done is issued for the aborted line.
- line_req and wr_req on the same IDLE edge: fetch wins and the write waits for a slot.
- clear_err and an underrun event in the same cycle: set wins.
- busy is 1 in FETCH and FLUSH.

## Timing
- All outputs except lb_wdata are registered.
- Reset values: lb_we=0, lb_waddr=0, line_done=0, wr_ack=0, sram_addr=0, sram_we=0, sram_wdata=0, busy=0, underrun=0. FSM returns to IDLE.
- Reset mid-fetch aborts silently: no line_done is issued.
- line_req sampled at edge t gives the first read address in cycle t+1.
- With no writer, reads occupy cycles t+1..t+H_DISP, the last lb_we is in t+H_DISP+1, and line_done is in t+H_DISP+2.
- Worst case with writer slots: H_DISP + floor((H_DISP-1)/WR_SLOT_PERIOD) = 999 read/write cycles. This fits the 1056-cycle line.
- Write grant: wr_req high at edge e (grant allowed) gives sram_we=1 and wr_ack=1 in cycle e+1, with sram_addr/sram_wdata = wr_addr/wr_data.
- IDLE write latency is 1 cycle. Write latency during FETCH is at most WR_SLOT_PERIOD+1 cycles.

## Test plan
- Fetch alone, writer idle: line_req with line_idx=2 → 800 reads at addresses 1600..2399 in consecutive cycles; lb_waddr 0..799 with data matching the SRAM model; line_done exactly 802 cycles after line_req.
- Writer continuously requesting during fetch of line 599: a write occurs after every 4th read, 199 writes total; reads end at address 479999; line_done by cycle 1001; no underrun.
- IDLE writes back-to-back with wr_req held high and the address changed on each ack: one ack every 2 cycles; each address written exactly once.
- line_req for line 10, then line_req for line 11 after 300 cycles: underrun=1; no line_done for line 10; line 11 fully fetched with lb_waddr restarting at 0. clear_err then gives underrun=0.
- line_req with line_idx=600, and line_req plus wr_req on the same edge:
  - line_idx=600 → no SRAM activity, busy stays 0, underrun stays 0.
  - Simultaneous line_req and wr_req → first cycle is a read; write acked at the first slot (cycle 5).
- rst asserted mid-fetch at col 400: next cycle all outputs are at reset values; no line_done; a subsequent line_req fetches normally.
